// File: rtl/sync_debounce_edge_pkg.sv
// Shared FSM state encoding and saturating-increment helper for the debouncer.
package sync_debounce_edge_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_e;

    // Increment v, holding at 2**w-1; counter widths up to 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [32:0] lim;
        lim = (33'd1 << w) - 33'd1;
        if ({1'b0, v} >= lim) begin
            return v;
        end
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/sync_debounce_edge_sat_counter.sv
// Saturating event counter with synchronous clear; an increment coinciding
// with clear yields 1 so the event is not lost.
module sync_debounce_edge_sat_counter
    import sync_debounce_edge_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = inc ? CNT_W'(1) : '0;
        end else if (inc) begin
            q_d = CNT_W'(sat_inc(32'(q_q), CNT_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sync_debounce_edge.sv
// Debounces an already-synchronised level: a new value must be sampled
// STABLE_CYCLES times in a row before it is accepted; shorter excursions count as glitches.
module sync_debounce_edge
    import sync_debounce_edge_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_in,
    input  logic             clr_cnt,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] rise_count,
    output logic [CNT_W-1:0] glitch_count
);

    localparam int unsigned RUN_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);

    state_e           state_q;
    logic [RUN_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    logic             rise_inc_c;
    logic             glitch_inc_c;

    // Counter events are decided this cycle so they land on the same edge as the pulses.
    always_comb begin
        rise_inc_c   = 1'b0;
        glitch_inc_c = 1'b0;
        if (state_q == WAIT_HIGH) begin
            rise_inc_c   = sync_in && (cnt_q == RUN_LAST);
            glitch_inc_c = !sync_in;
        end else if (state_q == WAIT_LOW) begin
            glitch_inc_c = sync_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IDLE_LOW: begin
                    if (sync_in) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= RUN_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (!sync_in) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == RUN_LAST) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + RUN_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_in) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= RUN_W'(1);
                    end
                end
                WAIT_LOW: begin
                    if (sync_in) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == RUN_LAST) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + RUN_W'(1);
                    end
                end
            endcase
        end
    end

    sync_debounce_edge_sat_counter #(
        .CNT_W (CNT_W)
    ) u_rise_cnt (
        .clk (clk),
        .rst (rst),
        .inc (rise_inc_c),
        .clr (clr_cnt),
        .q   (rise_count)
    );

    sync_debounce_edge_sat_counter #(
        .CNT_W (CNT_W)
    ) u_glitch_cnt (
        .clk (clk),
        .rst (rst),
        .inc (glitch_inc_c),
        .clr (clr_cnt),
        .q   (glitch_count)
    );

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed plus randomized bench comparing two debouncer instances (8-bit and
// 2-bit counters) against a run-length reference model.
module tb_sync_debounce_edge;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync_in;
    logic       clr_cnt;

    logic       level_out, rise_pulse, fall_pulse;
    logic [7:0] rise_count, glitch_count;
    logic       level_out2, rise_pulse2, fall_pulse2;
    logic [1:0] rise_count2, glitch_count2;

    int total = 0;
    int bad   = 0;

    // Reference model: accepted level and length of the current run of differing samples.
    int m_lvl, m_run, m_rise, m_fall;
    int m_rc, m_gc, m_rc2, m_gc2;

    always #5 clk = ~clk;

    sync_debounce_edge #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .sync_in      (sync_in),
        .clr_cnt      (clr_cnt),
        .level_out    (level_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .rise_count   (rise_count),
        .glitch_count (glitch_count)
    );

    sync_debounce_edge #(.STABLE_CYCLES(STABLE), .CNT_W(2)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .sync_in      (sync_in),
        .clr_cnt      (clr_cnt),
        .level_out    (level_out2),
        .rise_pulse   (rise_pulse2),
        .fall_pulse   (fall_pulse2),
        .rise_count   (rise_count2),
        .glitch_count (glitch_count2)
    );

    function automatic int bump(int v, int inc, int clr, int maxv);
        if (clr != 0) return inc;
        if (inc != 0) return (v >= maxv) ? v : v + 1;
        return v;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(int s, int clr, int r);
        int inc_r;
        int inc_g;
        inc_r = 0;
        inc_g = 0;
        if (r != 0) begin
            m_lvl = 0; m_run = 0; m_rise = 0; m_fall = 0;
            m_rc = 0; m_gc = 0; m_rc2 = 0; m_gc2 = 0;
            return;
        end
        m_rise = 0;
        m_fall = 0;
        if (s != m_lvl) begin
            m_run++;
            if (m_run == STABLE) begin
                m_lvl  = s;
                m_run  = 0;
                m_rise = s;
                m_fall = 1 - s;
                inc_r  = s;
            end
        end else begin
            if (m_run > 0) inc_g = 1;
            m_run = 0;
        end
        m_rc  = bump(m_rc,  inc_r, clr, 255);
        m_gc  = bump(m_gc,  inc_g, clr, 255);
        m_rc2 = bump(m_rc2, inc_r, clr, 3);
        m_gc2 = bump(m_gc2, inc_g, clr, 3);
    endtask

    // Apply one sampled cycle, advance the model, then compare all outputs.
    task automatic step(int s, int clr, int r);
        sync_in = 1'(s);
        clr_cnt = 1'(clr);
        rst     = 1'(r);
        @(posedge clk);
        model_edge(s, clr, r);
        #1;
        chk("level",      int'(level_out),     m_lvl);
        chk("rise",       int'(rise_pulse),    m_rise);
        chk("fall",       int'(fall_pulse),    m_fall);
        chk("rise_cnt",   int'(rise_count),    m_rc);
        chk("glitch_cnt", int'(glitch_count),  m_gc);
        chk("rise_cnt2",  int'(rise_count2),   m_rc2);
        chk("glitch2",    int'(glitch_count2), m_gc2);
        chk("level2",     int'(level_out2),    m_lvl);
    endtask

    initial begin
        int cur;
        m_lvl = 0; m_run = 0; m_rise = 0; m_fall = 0;
        m_rc = 0; m_gc = 0; m_rc2 = 0; m_gc2 = 0;

        // Reset with sync_in high, then rise on the 4th sampled 1.
        step(1, 0, 1);
        step(1, 0, 1);
        chk("rst_level", int'(level_out), 0);
        chk("rst_rise",  int'(rise_pulse), 0);
        chk("rst_rcnt",  int'(rise_count), 0);
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 0);
            chk("t1_rise", int'(rise_pulse), (k == 4) ? 1 : 0);
        end
        chk("t1_level", int'(level_out), 1);

        // Short high excursion is a glitch.
        step(0, 0, 1);
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        step(0, 0, 0);
        chk("t2_level",  int'(level_out), 0);
        chk("t2_glitch", int'(glitch_count), 1);

        // Accepted fall leaves rise_count alone.
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        chk("t3_rcnt", int'(rise_count), 1);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0);
            chk("t3_fall", int'(fall_pulse), (k == 4) ? 1 : 0);
        end
        chk("t3_level", int'(level_out), 0);
        step(0, 0, 0);
        chk("t3_fall_once", int'(fall_pulse), 0);
        chk("t3_rcnt2", int'(rise_count), 1);

        // Five rises: 2-bit counter saturates at 3.
        step(0, 0, 1);
        for (int n = 0; n < 5; n++) begin
            for (int k = 0; k < 4; k++) step(1, 0, 0);
            for (int k = 0; k < 4; k++) step(0, 0, 0);
        end
        chk("t4_rcnt8", int'(rise_count), 5);
        chk("t4_rcnt2", int'(rise_count2), 3);

        // Clear coinciding with a rise yields 1.
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        step(1, 1, 0);
        chk("t5_rise", int'(rise_pulse), 1);
        chk("t5_rcnt", int'(rise_count), 1);
        chk("t5_rcnt2", int'(rise_count2), 1);

        // Reset mid-run discards the partial run.
        step(0, 0, 1);
        step(1, 0, 0); step(1, 0, 0);
        step(1, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 0);
            chk("t6_rise", int'(rise_pulse), (k == 4) ? 1 : 0);
        end

        // Randomized bursts with occasional clear and reset.
        cur = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 4) == 0) cur = 1 - cur;
            step(cur, ($urandom_range(0, 60) == 0) ? 1 : 0,
                 ($urandom_range(0, 250) == 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
